ysyx_ifu_fetch_queue: RTL and testbench

- Multi-lane instruction fetch queue between IFU and IDU; generalises the single-instruction ifu→idu valid/ready hand-off to FETCH_WIDTH instructions per cycle.
- Buffers inst/pc/pnpc triples in a circular buffer and drains one per cycle to IDU in program order.
- Supports pipeline flush on redirect (branch mispredict, trap, fence.i).

---
 rtl/ysyx_ifu_fetch_queue.sv | 136 +++++++++++++
 tb/tb_ysyx_ifu_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_ifu_fetch_queue.sv
// ysyx_ifu_fetch_queue
//   Multi-lane instruction fetch queue between IFU and IDU. Each cycle it accepts up to
//   FETCH_WIDTH (inst, pc, pnpc) triples. It compacts the valid lanes into a circular
//   buffer and presents them to IDU one at a time, in program order.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   flush               drop every stored entry and any same-cycle enqueue
//   in_valid            per-lane valid mask (any pattern legal)
//   in_inst/pc/pnpc     packed lane data, lane i in the i-th slice
//   in_ready            room for a full FETCH_WIDTH group (registered count only)
//   out_valid           head entry present
//   out_inst/pc/pnpc    head entry fields (don't-care while out_valid=0)
//   out_ready           IDU accepts the head entry
//   count               occupied entries
module ysyx_ifu_fetch_queue #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [FETCH_WIDTH-1:0]      in_valid,
    input  logic [FETCH_WIDTH*32-1:0]   in_inst,
    input  logic [FETCH_WIDTH*XLEN-1:0] in_pc,
    input  logic [FETCH_WIDTH*XLEN-1:0] in_pnpc,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [31:0]                 out_inst,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_pnpc,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [CntW-1:0] free;
    logic [CntW-1:0] enq_cnt;
    logic [PtrW-1:0] lane_slot [FETCH_WIDTH];
    logic            enq;
    logic            deq;

    // Storage is deliberately not reset; only the pointers and count qualify it.
    logic [31:0]     mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_pnpc [DEPTH];

    // Handshake. in_ready looks only at the registered count, so out_ready has no
    // combinational path to in_ready.
    always_comb begin
        free      = CntW'(DEPTH) - count_q;
        in_ready  = free >= CntW'(FETCH_WIDTH);
        out_valid = count_q != '0;
        enq       = in_ready && (|in_valid) && !flush;
        deq       = out_valid && out_ready && !flush;
    end

    // Compaction: each valid lane lands at tail plus the number of valid lanes
    // below it, which keeps ascending lane order in consecutive slots.
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_slot[i] = tail_q + PtrW'(enq_cnt);
            enq_cnt      = enq_cnt + CntW'(in_valid[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem_inst[lane_slot[i]] <= in_inst[32*i +: 32];
                    mem_pc[lane_slot[i]]   <= in_pc[XLEN*i +: XLEN];
                    mem_pnpc[lane_slot[i]] <= in_pnpc[XLEN*i +: XLEN];
                end
            end
        end
    end

    // Next state. Flush takes priority over both enqueue and dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PtrW'(enq_cnt);
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + (enq ? enq_cnt : '0) - CntW'(deq);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_inst = mem_inst[head_q];
        out_pc   = mem_pc[head_q];
        out_pnpc = mem_pnpc[head_q];
        count    = count_q;
    end

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < FETCH_WIDTH) || (FETCH_WIDTH < 1))
    begin : g_bad_params
        $fatal(1, "ysyx_ifu_fetch_queue: DEPTH must be a power of two >= FETCH_WIDTH >= 1");
    end

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        count_q <= CntW'(DEPTH));
    a_enq_ready: assert property (@(posedge clock) disable iff (reset)
        enq |-> in_ready);

endmodule

// File: tb/tb_ysyx_ifu_fetch_queue.sv
module tb_ysyx_ifu_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FW    = 2;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pnpc;
    } ent_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [FW-1:0]        in_valid;
    logic [FW*32-1:0]     in_inst;
    logic [FW*XLEN-1:0]   in_pc;
    logic [FW*XLEN-1:0]   in_pnpc;
    logic                 in_ready;
    logic                 out_valid;
    logic [31:0]          out_inst;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_pnpc;
    logic                 out_ready;
    logic [$clog2(DEPTH):0] count;

    ysyx_ifu_fetch_queue #(
        .XLEN        (XLEN),
        .FETCH_WIDTH (FW),
        .DEPTH       (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_pnpc   (in_pnpc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_pnpc  (out_pnpc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    // Reference: plain FIFO of entries in program order.
    ent_t model[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model.size();
        chk("count", 64'(count), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= FW));
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        if (sz != 0) begin
            chk("out_inst", 64'(out_inst), 64'(model[0].inst));
            chk("out_pc", 64'(out_pc), 64'(model[0].pc));
            chk("out_pnpc", 64'(out_pnpc), 64'(model[0].pnpc));
        end
    endtask

    // Called at posedge+1: drive, check, advance the model, step one clock.
    task automatic step(input logic [FW-1:0] v, input logic [FW*XLEN-1:0] pcs,
                        input logic ordy, input logic fl);
        int   sz;
        ent_t e;
        in_valid  = v;
        in_pc     = pcs;
        for (int i = 0; i < FW; i++) begin
            in_inst[32*i +: 32]     = pcs[XLEN*i +: XLEN] ^ 32'hA5A5_0013;
            in_pnpc[XLEN*i +: XLEN] = pcs[XLEN*i +: XLEN] + 32'd4;
        end
        out_ready = ordy;
        flush     = fl;
        check_outputs();
        if (fl) begin
            model.delete();
        end else begin
            sz = model.size();
            if (ordy && sz > 0) void'(model.pop_front());
            if ((DEPTH - sz) >= FW) begin
                for (int i = 0; i < FW; i++) begin
                    if (v[i]) begin
                        e.inst = in_inst[32*i +: 32];
                        e.pc   = in_pc[XLEN*i +: XLEN];
                        e.pnpc = in_pnpc[XLEN*i +: XLEN];
                        model.push_back(e);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [FW*XLEN-1:0] pair(input logic [XLEN-1:0] pc0);
        return {pc0 + 32'd4, pc0};
    endfunction

    logic [FW*XLEN-1:0] rnd;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        in_inst   = '0;
        in_pc     = '0;
        in_pnpc   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_outputs();

        // Build count=5, then reset asynchronously between edges.
        step(2'b11, pair(32'h8000_1000), 1'b0, 1'b0);
        step(2'b11, pair(32'h8000_1008), 1'b0, 1'b0);
        step(2'b01, pair(32'h8000_1010), 1'b0, 1'b0);
        in_valid = '0;
        chk("pre_reset_count", 64'(count), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_count", 64'(count), 64'd0);
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_ready", 64'(in_ready), 64'd1);
        model.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill to full with out_ready=0, then attempt pushes while full.
        for (int g = 0; g < 4; g++) step(2'b11, pair(32'h8000_0000 + 32'(8 * g)), 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_pc", 64'(out_pc), 64'h8000_0000);
        step(2'b11, pair(32'h9000_0000), 1'b0, 1'b0);
        step(2'b01, pair(32'h9000_0010), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(2'b00, '0, 1'b1, 1'b0);

        // Sparse mask: only lane 1 valid.
        step(2'b10, {32'h8000_0104, 32'hDEAD_BEEF}, 1'b0, 1'b0);
        chk("sparse_count", 64'(count), 64'd1);
        chk("sparse_pc", 64'(out_pc), 64'h8000_0104);
        step(2'b11, {32'h8000_010C, 32'h8000_0108}, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(2'b00, '0, 1'b1, 1'b0);

        // Wrap-around: head=5, tail=6, then a group straddling slot 7 -> 0.
        step(2'b00, '0, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) step(2'b11, pair(32'h8000_2000 + 32'(8 * g)), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(2'b00, '0, 1'b1, 1'b0);
        step(2'b11, pair(32'h8000_3000), 1'b0, 1'b0);
        step(2'b11, pair(32'h8000_3008), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(2'b00, '0, 1'b1, 1'b0);
        chk("wrap_drained", 64'(count), 64'd0);

        // count=7 with out_ready=1: dequeue only, then push 2 + pop 1.
        for (int g = 0; g < 3; g++) step(2'b11, pair(32'h8000_4000 + 32'(8 * g)), 1'b0, 1'b0);
        step(2'b01, pair(32'h8000_4018), 1'b0, 1'b0);
        chk("seven_ready", 64'(in_ready), 64'd0);
        step(2'b11, pair(32'h8000_5000), 1'b1, 1'b0);
        chk("deq_only_count", 64'(count), 64'd6);
        step(2'b11, pair(32'h8000_5008), 1'b1, 1'b0);
        chk("push2_pop1_count", 64'(count), 64'd7);

        // Flush at count=4 with a same-cycle group and out_ready=1.
        for (int k = 0; k < 3; k++) step(2'b00, '0, 1'b1, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd4);
        step(2'b11, pair(32'h8000_6000), 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step(2'b11, pair(32'h8000_7000), 1'b0, 1'b0);
        chk("post_flush_pc", 64'(out_pc), 64'h8000_7000);
        step(2'b00, '0, 1'b0, 1'b1);
        step(2'b00, '0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rnd = {$urandom(), $urandom()};
            step(FW'($urandom()), rnd, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end
        for (int k = 0; k < DEPTH + 1; k++) step(2'b00, '0, 1'b1, 1'b0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
